// File: rtl/axi_ic_pkg.sv
// rtl/axi_ic_pkg.sv - shared AXI interconnect arbiter types and sizes
package axi_ic_pkg;

    localparam int NUM_MASTERS = 4;
    localparam int GNT_W       = NUM_MASTERS;
    localparam int ID_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority picker for four requesters
module rr_pick4
    import axi_ic_pkg::*;
(
    input  logic [GNT_W-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [GNT_W-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    logic [ID_W-1:0] k;

    // Walk ptr, ptr+1, ... with natural 2-bit wrap; first requester wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            k = ptr + ID_W'(i);
            if (!any && req[k]) begin
                any = 1'b1;
                idx = k;
                gnt = GNT_W'(1) << k;
            end
        end
    end

endmodule

// File: rtl/axi_arbiter_r.sv
// rtl/axi_arbiter_r.sv - four-master AXI read-channel arbiter with registered one-hot grant
module axi_arbiter_r
    import axi_ic_pkg::*;
#(
    parameter int RR_ENABLE = 1
) (
    input  logic       ACLK,
    input  logic       ARESET,
    input  logic       m0_ARVALID,
    input  logic       m1_ARVALID,
    input  logic       m2_ARVALID,
    input  logic       m3_ARVALID,
    input  logic       s_ARVALID,
    input  logic       m_ARREADY,
    input  logic       m_RVALID,
    input  logic       m_RLAST,
    input  logic       s_RREADY,
    output logic       m0_rgrnt,
    output logic       m1_rgrnt,
    output logic       m2_rgrnt,
    output logic       m3_rgrnt,
    output logic [1:0] r_grant_id,
    output logic       r_busy
);

    arb_state_t      state_q, state_nx;
    logic [GNT_W-1:0] grant_q, grant_nx;
    logic [ID_W-1:0]  id_q, id_nx;
    logic [ID_W-1:0]  ptr_q, ptr_nx;
    logic             busy_q;

    logic [GNT_W-1:0] req;
    logic [ID_W-1:0]  pick_base, pick_ptr, pick_idx;
    logic [GNT_W-1:0] pick_gnt;
    logic             pick_any;
    logic             ar_hs, last_beat, own_req;

    assign req       = {m3_ARVALID, m2_ARVALID, m1_ARVALID, m0_ARVALID};
    assign ar_hs     = s_ARVALID & m_ARREADY;
    assign last_beat = m_RVALID & s_RREADY & m_RLAST;
    assign own_req   = |(req & grant_q);

    // On a last beat the picker must already see the post-burst pointer.
    assign pick_base = (state_q == ST_DATA) ? id_q + 2'd1 : ptr_q;
    assign pick_ptr  = (RR_ENABLE != 0) ? pick_base : '0;

    rr_pick4 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_nx = state_q;
        grant_nx = grant_q;
        id_nx    = id_q;
        ptr_nx   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nx = ST_ADDR;
                    grant_nx = pick_gnt;
                    id_nx    = pick_idx;
                end
            end
            ST_ADDR: begin
                if (ar_hs) begin
                    state_nx = ST_DATA;
                end else if (!own_req) begin
                    state_nx = ST_IDLE;
                    grant_nx = '0;
                end
            end
            ST_DATA: begin
                if (last_beat) begin
                    ptr_nx = id_q + 2'd1;
                    if (pick_any) begin
                        state_nx = ST_ADDR;
                        grant_nx = pick_gnt;
                        id_nx    = pick_idx;
                    end else begin
                        state_nx = ST_IDLE;
                        grant_nx = '0;
                    end
                end
            end
            default: begin
                state_nx = ST_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            grant_q <= grant_nx;
            id_q    <= id_nx;
            ptr_q   <= ptr_nx;
            busy_q  <= (state_nx != ST_IDLE);
        end
    end

    assign m0_rgrnt   = grant_q[0];
    assign m1_rgrnt   = grant_q[1];
    assign m2_rgrnt   = grant_q[2];
    assign m3_rgrnt   = grant_q[3];
    assign r_grant_id = id_q;
    assign r_busy     = busy_q;

endmodule

// File: tb/tb_axi_arbiter_r.sv
// tb/tb_axi_arbiter_r.sv - randomized and directed bench for axi_arbiter_r against a behavioural model
module tb_axi_arbiter_r;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       arv, ardy, rv, rl, rrdy;

    logic       g0_r, g1_r, g2_r, g3_r, busy_r;
    logic [1:0] id_r;
    logic       g0_f, g1_f, g2_f, g3_f, busy_f;
    logic [1:0] id_f;

    int total = 0;
    int bad   = 0;

    // Model state: phase 0=idle 1=addr 2=data, owner index, rotation pointer.
    int ph_rr, own_rr, ptr_rr;
    int ph_fp, own_fp, ptr_fp;

    always #5 clk = ~clk;

    axi_arbiter_r #(.RR_ENABLE(1)) dut (
        .ACLK(clk), .ARESET(rst),
        .m0_ARVALID(req[0]), .m1_ARVALID(req[1]), .m2_ARVALID(req[2]), .m3_ARVALID(req[3]),
        .s_ARVALID(arv), .m_ARREADY(ardy), .m_RVALID(rv), .m_RLAST(rl), .s_RREADY(rrdy),
        .m0_rgrnt(g0_r), .m1_rgrnt(g1_r), .m2_rgrnt(g2_r), .m3_rgrnt(g3_r),
        .r_grant_id(id_r), .r_busy(busy_r)
    );

    axi_arbiter_r #(.RR_ENABLE(0)) dut_fp (
        .ACLK(clk), .ARESET(rst),
        .m0_ARVALID(req[0]), .m1_ARVALID(req[1]), .m2_ARVALID(req[2]), .m3_ARVALID(req[3]),
        .s_ARVALID(arv), .m_ARREADY(ardy), .m_RVALID(rv), .m_RLAST(rl), .s_RREADY(rrdy),
        .m0_rgrnt(g0_f), .m1_rgrnt(g1_f), .m2_rgrnt(g2_f), .m3_rgrnt(g3_f),
        .r_grant_id(id_f), .r_busy(busy_f)
    );

    wire [3:0] gv_r = {g0_r, g1_r, g2_r, g3_r};
    wire [3:0] gv_f = {g0_f, g1_f, g2_f, g3_f};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int arb(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++) begin
            if (r[(start + i) % 4]) return (start + i) % 4;
        end
        return -1;
    endfunction

    task automatic mstep(input bit rr, inout int ph, inout int own, inout int ptr);
        int w;
        if (rst) begin
            ph = 0; own = 0; ptr = 0;
        end else if (ph == 0) begin
            w = arb(req, rr ? ptr : 0);
            if (w >= 0) begin ph = 1; own = w; end
        end else if (ph == 1) begin
            if (arv && ardy) ph = 2;
            else if (!req[own]) ph = 0;
        end else if (rv && rrdy && rl) begin
            ptr = (own + 1) % 4;
            w = arb(req, rr ? ptr : 0);
            if (w >= 0) begin ph = 1; own = w; end
            else ph = 0;
        end
    endtask

    function automatic logic [3:0] exp_gv(input int ph, input int own);
        logic [3:0] g;
        g = 4'b0000;
        if (ph != 0) g[3 - own] = 1'b1;
        return g;
    endfunction

    task automatic step();
        mstep(1'b1, ph_rr, own_rr, ptr_rr);
        mstep(1'b0, ph_fp, own_fp, ptr_fp);
        @(posedge clk);
        #1;
        check_eq("rr_grant", gv_r, exp_gv(ph_rr, own_rr));
        check_eq("rr_id", id_r, own_rr);
        check_eq("rr_busy", busy_r, ph_rr != 0);
        check_eq("fp_grant", gv_f, exp_gv(ph_fp, own_fp));
        check_eq("fp_id", id_f, own_fp);
        check_eq("fp_busy", busy_f, ph_fp != 0);
    endtask

    task automatic idle_inputs();
        req = 4'b0; arv = 0; ardy = 0; rv = 0; rl = 0; rrdy = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        ph_rr = 0; own_rr = 0; ptr_rr = 0;
        ph_fp = 0; own_fp = 0; ptr_fp = 0;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        do_reset();
        check_eq("reset_grant", gv_r, 4'b0000);
        check_eq("reset_id", id_r, 0);

        // m1 and m3 requesting: m1 first, then m3 back-to-back
        req = 4'b1010;
        step();
        check_eq("r028_m1", gv_r, 4'b0100);
        arv = 1; ardy = 1; step(); arv = 0; ardy = 0;
        rv = 1; rrdy = 1; rl = 1; step(); rv = 0; rrdy = 0; rl = 0;
        check_eq("r028_m3", gv_r, 4'b0001);
        check_eq("r028_busy", busy_r, 1'b1);

        // all four requesting with single-beat bursts
        do_reset();
        req = 4'b1111;
        step();
        for (int b = 0; b < 5; b++) begin
            check_eq("r029_order", id_r, b % 4);
            check_eq("r030_fixed", id_f, 0);
            arv = 1; ardy = 1; step(); arv = 0; ardy = 0;
            rv = 1; rrdy = 1; rl = 1; step(); rv = 0; rrdy = 0; rl = 0;
        end

        // m2, 4-beat burst with a 3-cycle RREADY stall on beat 2
        do_reset();
        req = 4'b0100;
        step();
        check_eq("r031_grant", gv_r, 4'b0010);
        arv = 1; ardy = 1; step(); arv = 0; ardy = 0; req = 4'b0;
        rv = 1; rrdy = 1; step();
        rrdy = 0;
        for (int s = 0; s < 3; s++) begin
            step();
            check_eq("r031_stall", gv_r, 4'b0010);
        end
        rrdy = 1; step();
        step();
        rl = 1; step(); rv = 0; rrdy = 0; rl = 0;
        check_eq("r031_idle", gv_r, 4'b0000);

        // reset mid-burst
        do_reset();
        req = 4'b0001;
        step();
        arv = 1; ardy = 1; step(); arv = 0; ardy = 0; req = 4'b0;
        rv = 1; rrdy = 1; step();
        rst = 1; step(); rst = 0; rv = 0; rrdy = 0;
        check_eq("r032_grant", gv_r, 4'b0000);
        check_eq("r032_busy", busy_r, 1'b0);
        req = 4'b0100;
        step();
        check_eq("r032_m2", gv_r, 4'b0010);

        // abandoned request keeps the pointer
        do_reset();
        req = 4'b0010;
        step();
        check_eq("r033_m1", gv_r, 4'b0100);
        req = 4'b0000;
        step();
        check_eq("r033_idle", gv_r, 4'b0000);
        check_eq("r033_lastid", id_r, 1);
        req = 4'b1111;
        step();
        check_eq("r033_ptr", gv_r, 4'b1000);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req  = 4'($urandom_range(0, 15));
            arv  = 1'($urandom_range(0, 1));
            ardy = 1'($urandom_range(0, 1));
            rv   = 1'($urandom_range(0, 1));
            rrdy = 1'($urandom_range(0, 1));
            rl   = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_arbiter_r.md
AXI_ARBITER_R -- requirements
Module: axi_arbiter_r

Interface
REQ-001 The block SHALL have parameter RR_ENABLE, default 1: 1 = round-robin priority, 0 = fixed priority m0>m1>m2>m3.
REQ-002 The block SHALL have port ACLK, input, 1, the single clock; all logic is synchronous to its rising edge.
REQ-003 The block SHALL have port ARESET, input, 1, reset: synchronous and active-high.
REQ-004 The block SHALL have ports m0_ARVALID..m3_ARVALID, input, 1 each, per-master read-address request.
REQ-005 The block SHALL have port s_ARVALID, input, 1, the muxed ARVALID driven toward the slave.
REQ-006 The block SHALL have port m_ARREADY, input, 1, the slave ARREADY.
REQ-007 The block SHALL have ports m_RVALID and m_RLAST, input, 1 each, the slave RVALID and RLAST.
REQ-008 The block SHALL have port s_RREADY, input, 1, the muxed RREADY driven toward the slave.
REQ-009 The block SHALL have ports m0_rgrnt..m3_rgrnt, output, 1 each, registered one-hot read grant driving the read-channel mux.
REQ-010 The block SHALL have port r_grant_id, output, 2, the index of the current or last granted master.
REQ-011 The block SHALL have port r_busy, output, 1, high whenever any grant is asserted.

Function
REQ-012 The block SHALL implement three states: IDLE (no grant), ADDR (grant held, waiting for the AR handshake) and DATA (grant held, waiting for the last R beat).
REQ-013 In IDLE with any mN_ARVALID high, the block SHALL load the one-hot grant of the arbitration winner and enter ADDR at the next edge, giving one cycle from request to grant.
REQ-014 With RR_ENABLE=1, the search order SHALL start at pointer ptr and proceed ptr, ptr+1, ptr+2, ptr+3, all mod 4; with RR_ENABLE=0 the order SHALL always be 0,1,2,3.
REQ-015 In ADDR, s_ARVALID&m_ARREADY SHALL move the block to DATA with the grant unchanged; R signals SHALL be ignored in ADDR.
REQ-016 In ADDR, if the granted mN_ARVALID is low and no handshake occurs, the block SHALL drop the grant and return to IDLE (abandoned request).
REQ-017 In DATA, grants SHALL stay stable until m_RVALID&s_RREADY&m_RLAST; beats without RLAST and stalled beats SHALL NOT change state.
REQ-018 On the last beat, ptr SHALL update to (granted index + 1) mod 4 in the same edge.
REQ-019 On the last beat, if any mN_ARVALID is high, the block SHALL re-arbitrate using the updated ptr and go directly to ADDR with the new grant, with zero idle cycles; otherwise it SHALL go to IDLE.
REQ-020 The grant outputs SHALL be at most one-hot at all times; they SHALL be all-zero exactly in IDLE.
REQ-021 r_grant_id SHALL hold the last winner's index while in IDLE.
REQ-022 ARVALID changes on non-granted masters during ADDR or DATA SHALL have no effect.
REQ-023 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-024 ARESET high at any edge, including mid-ADDR or mid-DATA, SHALL force state IDLE, all grants 0, r_busy 0, r_grant_id 0 and ptr 0, so m0 has highest priority after reset.
REQ-025 ARESET SHALL take precedence over every simultaneous handshake or last-beat event.

Structure
REQ-026 The state encoding, NUM_MASTERS=4 and the grant width SHALL live in shared package axi_ic_pkg, reused by the write arbiter.
REQ-027 The rotating-priority picker SHALL be a combinational sub-module rr_pick4 (inputs: 4-bit request, 2-bit ptr; outputs: one-hot winner, 2-bit index, any-valid).

Verification
REQ-028 After reset, m1_ARVALID=1 and m3_ARVALID=1 held -> grant 4'b0100 (m1) one cycle later; after m1's last beat, grant 4'b0001 (m3) on the next edge with no idle cycle.
REQ-029 All four ARVALID held high, single-beat bursts (ARLEN=0) -> grant order m0,m1,m2,m3,m0; each master granted exactly once per four bursts.
REQ-030 RR_ENABLE=0, all four requesting -> m0 granted on every re-arbitration; m1..m3 starved.
REQ-031 m2 granted, 4-beat burst with RREADY stalled 3 cycles on beat 2 -> grant 4'b0010 held until RVALID&RREADY&RLAST, then IDLE if no requests remain.
REQ-032 m0 granted, ARESET pulsed for 1 cycle during beat 2 of 8 -> grants 0, r_busy 0 next edge; a subsequent m2 request is granted normally.
REQ-033 m1 granted in ADDR, m1_ARVALID drops before ARREADY -> return to IDLE with grants 0; the next request is arbitrated with ptr unchanged.
